// File: rtl/core_pkg.sv
// Shared definitions for the pipeline control logic of the 5-stage MIPS core.
//   hz_state_t   : hazard controller FSM states (RUN / HALT)
//   REG_ZERO     : architectural zero register number (never a real dependency)
//   pipe_ctrl_t  : the four pipeline-control bits that drive the PC and the
//                  IF/ID, ID/EX pipeline registers
package core_pkg;

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    HALT = 1'b1
  } hz_state_t;

  localparam int REG_ZERO = 0;

  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic if_id_flush;
    logic id_ex_flush;
  } pipe_ctrl_t;

endpackage

// File: rtl/hazard_ctrl_perf_cnt.sv
// perf_cnt: free-running performance counter with synchronous clear and
// increment enable. Wraps modulo 2^CNT_W.
//   clk   in  : clock
//   clr   in  : synchronous clear (takes priority over inc)
//   inc   in  : add one on this edge
//   count out : current count
module perf_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller for the 5-stage MIPS core.
// Detects load-use hazards (one bubble), flushes wrong-path instructions on a
// taken branch or a jump, freezes the pipeline on a syscall halt until the
// console resumes it, and keeps stall / flush / run-cycle counters.
//   clk, rst                       : clock, synchronous active-high reset
//   MemRead_id_ex, RegWrite_id_ex  : EX instruction is a load / writes a reg
//   regfile_write_num_id_ex        : EX destination register
//   regfile_read_num1/2_if_id      : ID rs / rt
//   use_rs_if_id, use_rt_if_id     : ID actually reads rs / rt
//   branch_taken_ex, jump_id       : control-flow redirects
//   halt_ex, resume                : syscall halt / console go pulse
//   pc_en, if_id_en                : load enables (combinational)
//   if_id_flush, id_ex_flush       : clear-to-NOP on next edge (combinational)
//   halted                         : pipeline frozen
//   stall_count, flush_count, run_count : performance counters
module hazard_ctrl
  import core_pkg::*;
#(
  parameter int CNT_W  = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MemRead_id_ex,
  input  logic              RegWrite_id_ex,
  input  logic [REG_AW-1:0] regfile_write_num_id_ex,
  input  logic [REG_AW-1:0] regfile_read_num1_if_id,
  input  logic [REG_AW-1:0] regfile_read_num2_if_id,
  input  logic              use_rs_if_id,
  input  logic              use_rt_if_id,
  input  logic              branch_taken_ex,
  input  logic              jump_id,
  input  logic              halt_ex,
  input  logic              resume,
  output logic              pc_en,
  output logic              if_id_en,
  output logic              if_id_flush,
  output logic              id_ex_flush,
  output logic              halted,
  output logic [CNT_W-1:0]  stall_count,
  output logic [CNT_W-1:0]  flush_count,
  output logic [CNT_W-1:0]  run_count
);

  localparam int N_CNT = 3;
  localparam int STALL_IDX = 0;
  localparam int FLUSH_IDX = 1;
  localparam int RUN_IDX = 2;

  hz_state_t  state_q;
  hz_state_t  state_d;
  pipe_ctrl_t ctrl;
  logic       lu;
  logic       stall_inc;
  logic       flush_inc;
  logic       run_inc;

  logic [N_CNT-1:0] cnt_inc;
  logic [CNT_W-1:0] cnt_val [N_CNT];

  // Load-use: the loaded value is not available for forwarding until after
  // MEM, so an ID consumer of the load's destination must wait one cycle.
  // Register zero is hardwired and never a real dependency.
  always_comb begin
    lu = MemRead_id_ex && RegWrite_id_ex &&
         (regfile_write_num_id_ex != REG_AW'(REG_ZERO)) &&
         (((regfile_read_num1_if_id == regfile_write_num_id_ex) && use_rs_if_id) ||
          ((regfile_read_num2_if_id == regfile_write_num_id_ex) && use_rt_if_id));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    ctrl.pc_en       = 1'b1;
    ctrl.if_id_en    = 1'b1;
    ctrl.if_id_flush = 1'b0;
    ctrl.id_ex_flush = 1'b0;
    stall_inc        = 1'b0;
    flush_inc        = 1'b0;
    run_inc          = 1'b0;

    unique case (state_q)
      RUN: begin
        run_inc = 1'b1;
        if (branch_taken_ex) begin
          // A taken branch kills both younger instructions, including any
          // load-use consumer, so the hazard is moot.
          ctrl.if_id_flush = 1'b1;
          ctrl.id_ex_flush = 1'b1;
          flush_inc        = 1'b1;
        end else if (halt_ex) begin
          ctrl.pc_en    = 1'b0;
          ctrl.if_id_en = 1'b0;
          state_d       = HALT;
        end else if (lu) begin
          // Hold PC and IF/ID, inject a bubble into EX. A jump in ID is
          // held too and will be decoded (and counted) again next cycle.
          ctrl.pc_en       = 1'b0;
          ctrl.if_id_en    = 1'b0;
          ctrl.id_ex_flush = 1'b1;
          stall_inc        = 1'b1;
        end else if (jump_id) begin
          ctrl.if_id_flush = 1'b1;
          flush_inc        = 1'b1;
        end
      end
      HALT: begin
        ctrl.pc_en    = 1'b0;
        ctrl.if_id_en = 1'b0;
        if (resume) begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  assign pc_en       = ctrl.pc_en;
  assign if_id_en    = ctrl.if_id_en;
  assign if_id_flush = ctrl.if_id_flush;
  assign id_ex_flush = ctrl.id_ex_flush;
  assign halted      = (state_q == HALT);

  assign cnt_inc[STALL_IDX] = stall_inc;
  assign cnt_inc[FLUSH_IDX] = flush_inc;
  assign cnt_inc[RUN_IDX]   = run_inc;

  generate
    for (genvar gi = 0; gi < N_CNT; gi++) begin : g_cnt
      perf_cnt #(
        .CNT_W(CNT_W)
      ) u_perf_cnt (
        .clk  (clk),
        .clr  (rst),
        .inc  (cnt_inc[gi]),
        .count(cnt_val[gi])
      );
    end
  endgenerate

  assign stall_count = cnt_val[STALL_IDX];
  assign flush_count = cnt_val[FLUSH_IDX];
  assign run_count   = cnt_val[RUN_IDX];

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       mem_rd, reg_wr;
  logic [4:0] dest, rs, rt;
  logic       use_rs, use_rt, br, jmp, hlt, res;

  logic        pc_en, if_id_en, if_id_flush, id_ex_flush, halted;
  logic [31:0] stall_count, flush_count, run_count;
  logic        pc_en4, if_id_en4, if_id_flush4, id_ex_flush4, halted4;
  logic [3:0]  stall_count4, flush_count4, run_count4;

  int n_checks = 0;
  int n_fail = 0;

  // reference model state
  bit          m_halted;
  logic [31:0] m_stall, m_flush, m_run;

  always #5 clk = ~clk;

  hazard_ctrl dut (
    .clk(clk), .rst(rst),
    .MemRead_id_ex(mem_rd), .RegWrite_id_ex(reg_wr),
    .regfile_write_num_id_ex(dest),
    .regfile_read_num1_if_id(rs), .regfile_read_num2_if_id(rt),
    .use_rs_if_id(use_rs), .use_rt_if_id(use_rt),
    .branch_taken_ex(br), .jump_id(jmp), .halt_ex(hlt), .resume(res),
    .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
    .id_ex_flush(id_ex_flush), .halted(halted),
    .stall_count(stall_count), .flush_count(flush_count), .run_count(run_count)
  );

  hazard_ctrl #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst),
    .MemRead_id_ex(mem_rd), .RegWrite_id_ex(reg_wr),
    .regfile_write_num_id_ex(dest),
    .regfile_read_num1_if_id(rs), .regfile_read_num2_if_id(rt),
    .use_rs_if_id(use_rs), .use_rt_if_id(use_rt),
    .branch_taken_ex(br), .jump_id(jmp), .halt_ex(hlt), .resume(res),
    .pc_en(pc_en4), .if_id_en(if_id_en4), .if_id_flush(if_id_flush4),
    .id_ex_flush(id_ex_flush4), .halted(halted4),
    .stall_count(stall_count4), .flush_count(flush_count4), .run_count(run_count4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic set_in(input bit m, input bit w, input int d, input int s, input int t,
                        input bit urs, input bit urt, input bit b, input bit j,
                        input bit h, input bit r);
    mem_rd = m; reg_wr = w; dest = 5'(d); rs = 5'(s); rt = 5'(t);
    use_rs = urs; use_rt = urt; br = b; jmp = j; hlt = h; res = r;
  endtask

  task automatic idle();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Called just after a falling edge with inputs applied: checks outputs
  // against the model, advances the model across the coming rising edge,
  // and returns at the next falling edge.
  task automatic cycle(input string tag);
    bit lu;
    bit e_pc, e_ifen, e_iff, e_idf;
    #2;
    lu = mem_rd && reg_wr && (dest != 0) &&
         (((rs == dest) && use_rs) || ((rt == dest) && use_rt));
    e_pc = 0; e_ifen = 0; e_iff = 0; e_idf = 0;
    if (!m_halted) begin
      if (br)       begin e_pc = 1; e_ifen = 1; e_iff = 1; e_idf = 1; end
      else if (hlt) begin end
      else if (lu)  begin e_idf = 1; end
      else if (jmp) begin e_pc = 1; e_ifen = 1; e_iff = 1; end
      else          begin e_pc = 1; e_ifen = 1; end
    end
    check({tag, ".halted"}, 32'(halted), 32'(m_halted));
    check({tag, ".stall"}, stall_count, m_stall);
    check({tag, ".flush"}, flush_count, m_flush);
    check({tag, ".run"}, run_count, m_run);
    check({tag, ".stall4"}, 32'(stall_count4), m_stall % 16);
    check({tag, ".flush4"}, 32'(flush_count4), m_flush % 16);
    check({tag, ".run4"}, 32'(run_count4), m_run % 16);
    if (!rst) begin
      check({tag, ".ctrl"}, {28'd0, pc_en, if_id_en, if_id_flush, id_ex_flush},
            {28'd0, e_pc, e_ifen, e_iff, e_idf});
      check({tag, ".ctrl4"}, {28'd0, pc_en4, if_id_en4, if_id_flush4, id_ex_flush4},
            {28'd0, e_pc, e_ifen, e_iff, e_idf});
    end
    $display("cyc %s rst=%0b br=%0b hlt=%0b lu=%0b jmp=%0b res=%0b | pc_en=%0b fl=%0b%0b halted=%0b st=%0d fl=%0d run=%0d",
             tag, rst, br, hlt, lu, jmp, res, pc_en, if_id_flush, id_ex_flush,
             halted, stall_count, flush_count, run_count);
    if (rst) begin
      m_halted = 0; m_stall = 0; m_flush = 0; m_run = 0;
    end else if (!m_halted) begin
      m_run++;
      if (br)       m_flush++;
      else if (hlt) m_halted = 1;
      else if (lu)  m_stall++;
      else if (jmp) m_flush++;
    end else if (res) begin
      m_halted = 0;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1; idle(); cycle("reset"); rst = 0;
  endtask

  initial begin
    m_halted = 0; m_stall = 0; m_flush = 0; m_run = 0;
    rst = 1; idle();
    @(negedge clk);
    cycle("por");
    rst = 0;
    idle(); cycle("reset_state");

    // load-use: lw $8 in EX, ID reads rs=8
    set_in(1, 1, 8, 8, 3, 1, 1, 0, 0, 0, 0); cycle("lu_rs");
    set_in(1, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0); cycle("lu_dest0");
    set_in(1, 1, 8, 8, 3, 0, 1, 0, 0, 0, 0); cycle("lu_no_use_rs");
    set_in(1, 1, 9, 3, 9, 0, 1, 0, 0, 0, 0); cycle("lu_rt");
    idle(); cycle("after_lu");
    check("stall_after_lu", stall_count, 32'd2);

    // taken branch with lu
    set_in(1, 1, 8, 8, 3, 1, 1, 1, 0, 0, 0); cycle("br_lu");
    idle(); cycle("after_br");
    check("flush_after_br", flush_count, 32'd1);

    // jump with lu, then jump alone
    set_in(1, 1, 8, 8, 3, 1, 1, 0, 1, 0, 0); cycle("jmp_lu");
    set_in(0, 0, 0, 8, 3, 1, 1, 0, 1, 0, 0); cycle("jmp");
    idle(); cycle("after_jmp");
    check("flush_after_jmp", flush_count, 32'd2);

    // halt, 5 idle cycles, resume (resume in RUN first to show it is ignored)
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1); cycle("resume_in_run");
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0); cycle("halt");
    for (int i = 0; i < 5; i++) begin idle(); cycle("halt_idle"); end
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1); cycle("resume");
    idle(); cycle("after_resume");

    // reset mid-HALT
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0); cycle("halt2");
    idle(); cycle("halt2_idle");
    do_reset();
    idle(); cycle("after_rst_halt");
    check("rst_halt_pc_en", 32'(pc_en), 32'd1);
    check("rst_halt_run", run_count, 32'd1);

    // counter wrap on the 4-bit instance: 17 consecutive lu cycles
    do_reset();
    for (int i = 0; i < 17; i++) begin
      set_in(1, 1, 5, 5, 0, 1, 0, 0, 0, 0, 0); cycle("lu_wrap");
    end
    idle(); cycle("after_wrap");
    check("wrap_stall4", 32'(stall_count4), 32'd1);

    // randomized traffic
    do_reset();
    for (int i = 0; i < 400; i++) begin
      set_in($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
             $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 1), $urandom_range(0, 1),
             $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0,
             $urandom_range(0, 15) == 0, $urandom_range(0, 3) == 0);
      rst = ($urandom_range(0, 99) == 0);
      cycle("rand");
      rst = 0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
